// File: rtl/event_eth_fragmenter.sv
// event_eth_fragmenter
//  Splits each ethclk event (ctrl word + AXI4S qword payload) into fragments of at
//  most 2**FRAG_LOG2 payload qwords, each prefixed with a header qword. Checks the
//  payload length against the ctrl word and pulses trunc/ovr errors on mismatch.
//  Optional feature macro: EVENT_FRAG_TRAILER_EN appends an XOR trailer qword to
//  every fragment and moves m_tlast onto it.
//  aresetn is asynchronous and active-high despite its name.
module event_eth_fragmenter #(
  parameter int FRAG_LOG2  = 10,
  parameter     ETHCLKTYPE = "NONE"
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_ctrl_tdata,
  input  logic        s_ctrl_tvalid,
  output logic        s_ctrl_tready,
  input  logic [63:0] s_data_tdata,
  input  logic        s_data_tvalid,
  output logic        s_data_tready,
  input  logic        s_data_tlast,
  output logic [63:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        trunc_err_o,
  output logic        ovr_err_o,
  output logic [31:0] frag_count_o
);

  localparam logic [20:0] MAXQ = 21'(1) << FRAG_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DRAIN, S_TRL} state_t;

  state_t             state, beat_next;
  logic [11:0]        tag, frag_num;
  logic [19:0]        remaining, rem_dec, ctrl_len;
  logic [FRAG_LOG2:0] frag_left, fl_dec, hdr_len;
  logic               ctrl_rdy, load_en, beat, hdr_last, frag_end;
  logic [63:0]        hdr_word;
`ifdef EVENT_FRAG_TRAILER_EN
  state_t             ret_state;
  logic [63:0]        xor_acc;
`endif

  // Clock-domain tag hook for constraint attributes; no logic attached.
  if (ETHCLKTYPE != "NONE") begin : g_clk_tagged
  end

  // Output register loads whenever it is empty or being drained this cycle.
  assign load_en       = !m_tvalid || m_tready;
  assign s_ctrl_tready = ctrl_rdy;
  assign s_data_tready = ((state == S_DATA) && load_en) || (state == S_DRAIN);
  assign beat          = (state == S_DATA) && s_data_tvalid && load_en;

  // A zero length is treated as a one-qword event.
  assign ctrl_len = (s_ctrl_tdata[19:0] == '0) ? 20'd1 : s_ctrl_tdata[19:0];

  assign hdr_last = ({1'b0, remaining} <= MAXQ);
  assign hdr_len  = hdr_last ? remaining[FRAG_LOG2:0] : MAXQ[FRAG_LOG2:0];
  assign hdr_word = {tag, frag_num, hdr_last, 7'b0, 16'b0, 16'(hdr_len)};

  assign rem_dec  = remaining - 20'd1;
  assign fl_dec   = frag_left - 1'b1;
  assign frag_end = s_data_tlast || (rem_dec == '0) || (fl_dec == '0);

  // Where the FSM goes after the current payload beat (tlast has priority).
  always_comb begin
    beat_next = S_DATA;
    if (s_data_tlast)         beat_next = S_IDLE;
    else if (rem_dec == '0)   beat_next = S_DRAIN;
    else if (fl_dec == '0)    beat_next = S_HDR;
  end

  // Fragmenter FSM, output register, error pulses and fragment counter.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      state        <= S_IDLE;
      tag          <= '0;
      frag_num     <= '0;
      remaining    <= '0;
      frag_left    <= '0;
      ctrl_rdy     <= 1'b0;
      m_tdata      <= '0;
      m_tvalid     <= 1'b0;
      m_tlast      <= 1'b0;
      trunc_err_o  <= 1'b0;
      ovr_err_o    <= 1'b0;
      frag_count_o <= '0;
`ifdef EVENT_FRAG_TRAILER_EN
      ret_state    <= S_IDLE;
      xor_acc      <= '0;
`endif
    end else begin
      trunc_err_o <= 1'b0;
      ovr_err_o   <= 1'b0;
      if (load_en) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
      if (m_tvalid && m_tready && m_tlast) frag_count_o <= frag_count_o + 32'd1;

      case (state)
        S_IDLE: begin
          if (s_ctrl_tvalid && ctrl_rdy) begin
            tag       <= s_ctrl_tdata[31:20];
            remaining <= ctrl_len;
            frag_num  <= '0;
            ctrl_rdy  <= 1'b0;
            state     <= S_HDR;
          end else begin
            ctrl_rdy  <= 1'b1;
          end
        end
        S_HDR: begin
          if (load_en) begin
            m_tdata   <= hdr_word;
            m_tvalid  <= 1'b1;
            m_tlast   <= 1'b0;
            frag_left <= hdr_len;
`ifdef EVENT_FRAG_TRAILER_EN
            xor_acc   <= '0;
`endif
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat) begin
            m_tdata   <= s_data_tdata;
            m_tvalid  <= 1'b1;
            remaining <= rem_dec;
            frag_left <= fl_dec;
            if (s_data_tlast && (rem_dec != '0))  trunc_err_o <= 1'b1;
            if (!s_data_tlast && (rem_dec == '0)) ovr_err_o   <= 1'b1;
            if (!s_data_tlast && (rem_dec != '0) && (fl_dec == '0))
              frag_num <= frag_num + 12'd1;
`ifdef EVENT_FRAG_TRAILER_EN
            xor_acc   <= xor_acc ^ s_data_tdata;
            m_tlast   <= 1'b0;
            if (frag_end) begin
              ret_state <= beat_next;
              state     <= S_TRL;
            end
`else
            m_tlast   <= frag_end;
            state     <= beat_next;
            if (beat_next == S_IDLE) ctrl_rdy <= 1'b1;
`endif
          end
        end
`ifdef EVENT_FRAG_TRAILER_EN
        S_TRL: begin
          if (load_en) begin
            m_tdata  <= xor_acc;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b1;
            state    <= ret_state;
            if (ret_state == S_IDLE) ctrl_rdy <= 1'b1;
          end
        end
`endif
        S_DRAIN: begin
          // Surplus payload is swallowed until the source's tlast.
          if (s_data_tvalid && s_data_tlast) begin
            state    <= S_IDLE;
            ctrl_rdy <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
